inst_mem_writer: RTL

INST_MEM_WRITER -- requirements
Module: inst_mem_writer

---
 rtl/inst_mem_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_mem_writer                                              |
// | Description : Stores switch-entered instructions into an instruction       |
// |               memory, verifies each write by read-back, and clears memory. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inst_mem_writer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_btn,
  input  logic          clr_btn,
  input  logic [DW-1:0] instruction,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          busy,
  output logic          verify_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  localparam logic [2:0]    c_HALT_OP   = 3'b111;
  localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] c_ADR_ONE   = AW'(1);
  localparam logic [AW-1:0] c_LAST_ADR  = AW'(DEPTH - 1);

  state_t        r_state, w_stateNext;
  logic          r_wrSample, r_wrPrev, r_clrSample, r_clrPrev;
  logic          w_wrEdge, w_clrEdge;
  logic [DW-1:0] r_capture, w_captureNext;
  logic [AW-1:0] r_wrPtr, w_wrPtrNext;
  logic [AW-1:0] r_clrAdr, w_clrAdrNext;
  logic [AW:0]   r_count, w_countNext;
  logic [AW:0]   w_countInc;
  logic          r_done, w_doneNext;
  logic          r_verifyErr, w_verifyErrNext;
  logic          w_match, w_halt;

  // Edges come from two registered samples so no output depends on a raw input.
  assign w_wrEdge   = r_wrSample & ~r_wrPrev;
  assign w_clrEdge  = r_clrSample & ~r_clrPrev;
  assign w_match    = (mem_rdata == r_capture);
  assign w_halt     = (r_capture[DW-1 -: 3] == c_HALT_OP);
  assign w_countInc = r_count + c_CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wrSample  <= 1'b1;
      r_wrPrev    <= 1'b1;
      r_clrSample <= 1'b1;
      r_clrPrev   <= 1'b1;
      r_capture   <= '0;
      r_wrPtr     <= '0;
      r_clrAdr    <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_verifyErr <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_wrSample  <= wr_btn;
      r_wrPrev    <= r_wrSample;
      r_clrSample <= clr_btn;
      r_clrPrev   <= r_clrSample;
      r_capture   <= w_captureNext;
      r_wrPtr     <= w_wrPtrNext;
      r_clrAdr    <= w_clrAdrNext;
      r_count     <= w_countNext;
      r_done      <= w_doneNext;
      r_verifyErr <= w_verifyErrNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_captureNext   = r_capture;
    w_wrPtrNext     = r_wrPtr;
    w_clrAdrNext    = r_clrAdr;
    w_countNext     = r_count;
    w_doneNext      = r_done;
    w_verifyErrNext = r_verifyErr;
    case (r_state)
      ST_IDLE: begin
        // Clear has priority over a simultaneous store request.
        if (w_clrEdge) begin
          w_stateNext  = ST_CLEAR;
          w_clrAdrNext = '0;
        end else if (w_wrEdge) begin
          w_captureNext = instruction;
          w_stateNext   = ST_WRITE;
        end
      end
      ST_WRITE: w_stateNext = ST_CHECK;
      ST_CHECK: begin
        if (w_match) begin
          w_wrPtrNext = (r_wrPtr == c_LAST_ADR) ? '0 : r_wrPtr + c_ADR_ONE;
          w_countNext = w_countInc;
          if (w_halt) begin
            w_doneNext  = 1'b1;
            w_stateNext = ST_LOCKED;
          end else if (w_countInc == c_DEPTH_CNT) begin
            w_stateNext = ST_LOCKED;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end else begin
          w_verifyErrNext = 1'b1;
          w_stateNext     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (r_clrAdr == c_LAST_ADR) begin
          w_clrAdrNext    = '0;
          w_wrPtrNext     = '0;
          w_countNext     = '0;
          w_doneNext      = 1'b0;
          w_verifyErrNext = 1'b0;
          w_stateNext     = ST_IDLE;
        end else begin
          w_clrAdrNext = r_clrAdr + c_ADR_ONE;
        end
      end
      ST_LOCKED: begin
        if (w_clrEdge) begin
          w_stateNext  = ST_CLEAR;
          w_clrAdrNext = '0;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = r_wrPtr;
    mem_wdata = '0;
    case (r_state)
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = r_capture;
      end
      ST_CLEAR: begin
        mem_we  = 1'b1;
        mem_adr = r_clrAdr;
      end
      default: ;
    endcase
  end

  assign busy       = (r_state == ST_WRITE) || (r_state == ST_CHECK) || (r_state == ST_CLEAR);
  assign wr_ptr     = r_wrPtr;
  assign count      = r_count;
  assign full       = (r_count == c_DEPTH_CNT);
  assign done       = r_done;
  assign verify_err = r_verifyErr;

endmodule
`default_nettype wire
